unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the pipeline's instruction-fetch port (I, read-only)
//  and data port (D, load/store). Sits between the MIPS core and the RAM in the top level.
//  Sequences every access through a small FSM and returns a one-cycle valid pulse.
//  Exports per-port stall terms to the hazard unit. D has priority, with an anti-starvation limit for I.
// PARAMETERS
//  ADDR_W        8   RAM word-address width; mem_addr = byte_addr[ADDR_W+1:2], upper bits ignored
//  MAX_D_STREAK  4   consecutive D grants allowed while i_req is pending before I is forced
// PORTS
//  clk        in   1       single clock; all state on rising edge
//  rst        in   1       asynchronous, active-low reset
//  i_req      in   1       fetch request; held high with i_addr stable until i_valid
//  i_addr     in   32      fetch byte address (pc)
//  i_cancel   in   1       pipeline flush; kills an in-flight fetch's i_valid
//  i_rdata    out  32      fetched instruction, qualified by i_valid
//  i_valid    out  1       one-cycle completion pulse for I
//  i_stall    out  1       i_req & ~i_valid
//  d_req      in   1       data request; held with d_addr/d_we/d_wdata stable until d_valid
//  d_we       in   4       byte write enables; 4'b0000 = load
//  d_addr     in   32      data byte address
//  d_wdata    in   32      store data
//  d_rdata    out  32      load data, qualified by d_valid
//  d_valid    out  1       one-cycle completion pulse for D (loads and stores)
//  d_stall    out  1       d_req & ~d_valid
//  mem_en     out  1       RAM enable
//  mem_we     out  4       RAM byte write enables (0 for I grants)
//  mem_addr   out  ADDR_W  RAM word address
//  mem_wdata  out  32      RAM write data
//  mem_rdata  in   32      RAM read data; valid the cycle after mem_en
// BEHAVIOUR
//  - States: IDLE, I_ACC, D_ACC. Reset -> IDLE.
//  - Reset values: i_valid=d_valid=0, i_rdata=d_rdata=0, streak=0. mem_en, mem_we forced 0 while rst low.
//  - IDLE, cycle N: arbitrate on i_req/d_req. Drive mem_* combinationally from the winner in N.
//    Go to I_ACC or D_ACC at edge N+1. No request: stay IDLE, mem_en=0.
//  - Priority: D wins a tie unless streak==MAX_D_STREAK; then I wins.
//  - streak: +1 on each D grant while i_req=1, saturating at MAX_D_STREAK.
//    Cleared on any I grant, or when IDLE sees i_req=0.
//  - X_ACC, cycle N+1: capture mem_rdata into X_rdata (registered output, valid in N+2).
//    Assert X_valid in N+2 as a registered pulse, then return to IDLE in N+2.
//    Stores: d_valid is pulsed identically; d_rdata is don't-care.
//  - No grant is made in an ACC state. Max throughput is 1 access per 2 cycles.
//    Request-to-valid latency is 2 cycles when uncontended.
//  - The requester may drop req only in the valid cycle, or raise it again the following cycle.
//    Req seen high in the valid cycle is a NEW request (IDLE arbitrates it that cycle).
//  - i_cancel=1 in I_ACC, or in the cycle i_valid would rise: suppress that i_valid and leave i_rdata unchanged.
//    i_cancel in IDLE has no effect. The RAM read still occurs; no write side effects.
//  - d_req never cancelled. Misalignment is not checked; d_addr[1:0] is ignored.
//  - Async reset mid-access: immediate IDLE, valids cleared, access abandoned.
//    A store whose edge already occurred is not rolled back.
//  - Stall outputs are combinational; no combinational path from mem_rdata to any output.
// STRUCTURE
//  - Shared package mem_arb_pkg: state encoding (IDLE=2'd0, I_ACC=2'd1, D_ACC=2'd2), ADDR_W default,
//    WE_NONE=4'b0000.
//  - Sub-module arb_starve_ctr: saturating streak counter (inc/clr/sat outputs), width $clog2(MAX_D_STREAK+1).
//  - Top: FSM, grant mux to mem_*, response registers.
// TESTING
//  1. i_req only, i_addr=0x10, mem holds 0x2002_0005 at word 4 -> mem_addr=4 in N; i_valid in N+2; i_rdata=0x20020005.
//  2. d_req load and i_req together -> D granted first (d_valid N+2). I granted in N+2, i_valid N+4. i_stall high N..N+3.
//  3. d_req held continuously with i_req, MAX_D_STREAK=4 -> 4 D grants, then 1 I grant, streak back to 0.
//  4. store d_we=4'b1111, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=4'hF, mem_addr=16; load of 0x40 returns 0xDEADBEEF.
//  5. i_cancel pulsed during I_ACC -> no i_valid; FSM in IDLE at N+2; next fetch proceeds normally.
//  6. rst low during D_ACC -> i_valid=d_valid=0, mem_en=0, state IDLE; after release, a pending req is served in 2 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the unified memory arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam logic [3:0] WE_NONE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of consecutive D grants made over a waiting I request
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = (count == W'(MAX));

  // clear wins over increment; increment stops at MAX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one synchronous RAM between the fetch and data ports
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic              i_cancel,
  output logic [31:0]       i_rdata,
  output logic              i_valid,
  output logic              i_stall,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arb_state_t    state;
  logic          grant_d;
  logic          grant_i;
  logic          streak_inc;
  logic          streak_clr;
  logic          streak_sat;
  logic [SW-1:0] streak;
  logic          i_valid_q;
  logic [31:0]   i_cap;
  logic [31:0]   i_rdata_q;
  logic          i_deliver;
  logic          unused_addr_bits;

  // byte-offset and above-RAM address bits carry no meaning here
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  // D wins ties unless I has been passed over MAX_D_STREAK times in a row
  assign grant_d = (state == IDLE) && d_req && !(i_req && streak_sat);
  assign grant_i = (state == IDLE) && i_req && !grant_d;

  assign streak_inc = grant_d && i_req;
  assign streak_clr = grant_i || ((state == IDLE) && !i_req);

  arb_starve_ctr #(
    .MAX (MAX_D_STREAK)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (streak_inc),
    .clr   (streak_clr),
    .count (streak),
    .sat   (streak_sat)
  );

  // RAM request is steered from the winner in the arbitration cycle; silenced in reset
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = WE_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (grant_d) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr[ADDR_W+1:2];
        mem_wdata = d_wdata;
      end else if (grant_i) begin
        mem_en    = 1'b1;
        mem_addr  = i_addr[ADDR_W+1:2];
      end
    end
  end

  // access sequencer: grant in IDLE, capture read data in the ACC cycle, pulse valid on return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      i_valid_q <= 1'b0;
      d_valid   <= 1'b0;
      i_cap     <= '0;
      d_rdata   <= '0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= D_ACC;
          end else if (grant_i) begin
            state <= I_ACC;
          end
        end
        I_ACC: begin
          state <= IDLE;
          // a flush during the access drops the fetch; the RAM read is simply discarded
          if (!i_cancel) begin
            i_cap     <= mem_rdata;
            i_valid_q <= 1'b1;
          end
        end
        D_ACC: begin
          state   <= IDLE;
          d_rdata <= mem_rdata;
          d_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a flush arriving in the valid cycle itself still kills the fetch and keeps the old word
  assign i_deliver = i_valid_q && !i_cancel;
  assign i_valid   = i_deliver;
  assign i_rdata   = i_deliver ? i_cap : i_rdata_q;

  // last delivered instruction, held while a fetch is cancelled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
    end else if (i_deliver) begin
      i_rdata_q <= i_cap;
    end
  end

  assign i_stall = i_req && !i_valid;
  assign d_stall = d_req && !d_valid;

endmodule
